// File: rtl/fifo_stream_reader.sv
// Read-side drain controller for a BRAM-backed FIFO: hides the one-cycle read
// latency behind a 2-entry buffer and presents a valid/ready stream with frame marking.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  fifo_empty_i,
  input  logic                  fifo_wr_en_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_rd_en_o,
  input  logic                  flush_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic [CNT_W-1:0]      beat_cnt_o
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

  logic                  rd_vld_p0;
  logic [1:0]            occ_p1;
  logic [DATA_WIDTH-1:0] head_p1;
  logic [DATA_WIDTH-1:0] tail_p1;
  logic [CNT_W-1:0]      beat_cnt;
  logic                  pop;
  logic [1:0]            owned;

  assign pop   = (occ_p1 != 2'd0) & m_ready_i;
  // Words already committed to the buffer, including one still coming back from BRAM.
  assign owned = occ_p1 + {1'b0, rd_vld_p0};

  assign fifo_rd_en_o = rstn_i & ~fifo_empty_i & ~fifo_wr_en_i & ~flush_i &
                        ((owned < 2'd2) | ((owned == 2'd2) & pop));

  // Stage p0 -> p1: returning BRAM word lands in the buffer tail
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_vld_p0 <= 1'b0;
      occ_p1    <= 2'd0;
      head_p1   <= '0;
      tail_p1   <= '0;
    end else if (flush_i) begin
      rd_vld_p0 <= 1'b0;
      occ_p1    <= 2'd0;
    end else begin
      rd_vld_p0 <= fifo_rd_en_o;
      case ({rd_vld_p0, pop})
        2'b10: begin
          if (occ_p1 == 2'd0) head_p1 <= fifo_data_i;
          else                tail_p1 <= fifo_data_i;
          occ_p1 <= occ_p1 + 2'd1;
        end
        2'b01: begin
          head_p1 <= tail_p1;
          occ_p1  <= occ_p1 - 2'd1;
        end
        2'b11: begin
          if (occ_p1 == 2'd1) begin
            head_p1 <= fifo_data_i;
          end else begin
            head_p1 <= tail_p1;
            tail_p1 <= fifo_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p1 -> stream: beat counting per frame
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      beat_cnt <= '0;
    end else if (flush_i) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
    end
  end

  assign m_valid_o  = (occ_p1 != 2'd0);
  assign m_data_o   = head_p1;
  assign m_last_o   = m_valid_o & (beat_cnt == LAST_BEAT);
  assign beat_cnt_o = beat_cnt;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-level reference of the stream plus directed
// scenarios; two instances (16- and 4-beat frames) share one FIFO model and stimulus.
module tb_fifo_stream_reader;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        fifo_empty;
  logic        fifo_wr_en;
  logic [31:0] fifo_wdata;
  logic [31:0] fifo_data = '0;
  logic        flush;
  logic        m_ready;

  logic        rd16, valid16, last16;
  logic [31:0] data16;
  logic [15:0] cnt16;
  logic        rd4, valid4, last4;
  logic [31:0] data4;
  logic [15:0] cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  fifo_stream_reader #(.DATA_WIDTH(32), .FRAME_LEN(16), .CNT_W(16)) dut16 (
    .clk_i(clk_i), .rstn_i(rstn_i), .fifo_empty_i(fifo_empty), .fifo_wr_en_i(fifo_wr_en),
    .fifo_data_i(fifo_data), .fifo_rd_en_o(rd16), .flush_i(flush), .m_valid_o(valid16),
    .m_ready_i(m_ready), .m_data_o(data16), .m_last_o(last16), .beat_cnt_o(cnt16));

  fifo_stream_reader #(.DATA_WIDTH(32), .FRAME_LEN(4), .CNT_W(16)) dut4 (
    .clk_i(clk_i), .rstn_i(rstn_i), .fifo_empty_i(fifo_empty), .fifo_wr_en_i(fifo_wr_en),
    .fifo_data_i(fifo_data), .fifo_rd_en_o(rd4), .flush_i(flush), .m_valid_o(valid4),
    .m_ready_i(m_ready), .m_data_o(data4), .m_last_o(last4), .beat_cnt_o(cnt4));

  // Simple synchronous FIFO with one-cycle read data; reads are ignored in write cycles.
  logic [31:0] fifo_mem [256];
  logic [7:0]  wr_ptr = '0;
  logic [7:0]  rd_ptr = '0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk_i) begin
    if (fifo_wr_en) begin
      fifo_mem[wr_ptr] <= fifo_wdata;
      wr_ptr <= wr_ptr + 8'd1;
    end
    if (rd16 && !fifo_wr_en && !fifo_empty) begin
      fifo_data <= fifo_mem[rd_ptr];
      rd_ptr <= rd_ptr + 8'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: words owned by the reader as a queue plus one word on its way back.
  logic [31:0] mq [$];
  bit          pend;
  logic [31:0] pend_w;
  int          beats16, beats4;
  bit          e_valid, e_pop, e_rd;
  int          owned;

  always @(negedge clk_i) begin
    if (!rstn_i) begin
      mq.delete();
      pend    = 1'b0;
      beats16 = 0;
      beats4  = 0;
      chk("rst_valid", 32'(valid16), 32'd0);
      chk("rst_last",  32'(last16),  32'd0);
      chk("rst_data",  data16,       32'd0);
      chk("rst_cnt",   32'(cnt16),   32'd0);
      chk("rst_rd",    32'(rd16),    32'd0);
    end else begin
      e_valid = (mq.size() != 0);
      e_pop   = e_valid && m_ready;
      owned   = mq.size() + (pend ? 1 : 0);
      e_rd    = !fifo_empty && !fifo_wr_en && !flush && (owned < 2 || (owned == 2 && e_pop));
      chk("valid16", 32'(valid16), 32'(e_valid));
      chk("valid4",  32'(valid4),  32'(e_valid));
      if (e_valid) begin
        chk("data16", data16, mq[0]);
        chk("data4",  data4,  mq[0]);
      end
      chk("last16", 32'(last16), 32'(e_valid && beats16 == 15));
      chk("last4",  32'(last4),  32'(e_valid && beats4 == 3));
      chk("cnt16",  32'(cnt16),  32'(beats16));
      chk("cnt4",   32'(cnt4),   32'(beats4));
      chk("rd16",   32'(rd16),   32'(e_rd));
      chk("rd4",    32'(rd4),    32'(e_rd));
      if (flush) begin
        mq.delete();
        pend    = 1'b0;
        beats16 = 0;
        beats4  = 0;
      end else begin
        if (e_pop) begin
          void'(mq.pop_front());
          beats16 = (beats16 == 15) ? 0 : beats16 + 1;
          beats4  = (beats4 == 3) ? 0 : beats4 + 1;
        end
        if (pend) mq.push_back(pend_w);
        pend = e_rd;
        if (e_rd) pend_w = fifo_mem[rd_ptr];
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_words(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_wr_en = 1'b1;
      fifo_wdata = 32'(base + i);
      step();
    end
    fifo_wr_en = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  logic [63:0] rdy_pat = 64'hB5E3_96F7_3C5B_E97D;
  int first_rd, last_rd, rd_cnt, first_vld, lasts, last_data, pops, bad, first_pop;
  logic [31:0] got [$];
  bit seen;

  initial begin
    rstn_i = 1'b0; fifo_wr_en = 1'b0; fifo_wdata = '0; flush = 1'b0; m_ready = 1'b0;
    repeat (3) step();
    chk("reset_valid", 32'(valid16), 32'd0);
    chk("reset_data",  data16,       32'd0);
    rstn_i = 1'b1;
    step();

    // Full frame at full throughput
    m_ready = 1'b1;
    push_words(1, 16);
    first_rd = -1; last_rd = -1; rd_cnt = 0; first_vld = -1; lasts = 0; last_data = 0;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk_i);
      if (rd16) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = c;
        last_rd = c;
      end
      if (valid16 && first_vld < 0) first_vld = c;
      if (valid16 && last16) begin
        lasts++;
        last_data = int'(data16);
      end
      step();
    end
    chk("t1_rd_count",   32'(rd_cnt), 32'd16);
    chk("t1_rd_span",    32'(last_rd - first_rd), 32'd15);
    chk("t1_first_rd",   32'(first_rd), 32'd0);
    chk("t1_latency",    32'(first_vld - first_rd), 32'd2);
    chk("t1_last_count", 32'(lasts), 32'd1);
    chk("t1_last_data",  32'(last_data), 32'h10);
    chk("t1_cnt_wrap",   32'(cnt16), 32'd0);

    // Backpressure: two reads then stall, head held
    m_ready = 1'b0;
    push_words(1, 16);
    rd_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (rd16) rd_cnt++;
      if (c >= 2) chk("t2_head_hold", data16, 32'h1);
      step();
    end
    chk("t2_rd_count", 32'(rd_cnt), 32'd2);
    m_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 25; c++) begin
      @(negedge clk_i);
      if (valid16 && m_ready) got.push_back(data16);
      step();
    end
    chk("t2_pop_count", 32'(got.size()), 32'd16);
    if (got.size() == 16) begin
      chk("t2_first", got[0], 32'h1);
      chk("t2_final", got[15], 32'h10);
    end

    // Writes interleaved with draining
    push_words(32'h301, 8);
    bad = 0; pops = 0;
    for (int c = 0; c < 30; c++) begin
      fifo_wr_en = (c % 2 == 0);
      fifo_wdata = 32'(32'h310 + c);
      @(negedge clk_i);
      if (rd16 && fifo_wr_en) bad++;
      if (valid16 && m_ready) pops++;
      step();
    end
    fifo_wr_en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (valid16 && m_ready) pops++;
      step();
    end
    chk("t3_rd_wr_overlap", 32'(bad), 32'd0);
    chk("t3_pop_count",     32'(pops), 32'd23);

    // Random-looking ready pattern, 4-beat frames
    pulse_flush();
    m_ready = 1'b0;
    push_words(32'h401, 40);
    pops = 0; lasts = 0; bad = 0;
    for (int c = 0; c < 400 && pops < 40; c++) begin
      m_ready = rdy_pat[c % 64];
      @(negedge clk_i);
      if (valid4 && m_ready) begin
        pops++;
        if (last4 != (pops % 4 == 0)) bad++;
        if (last4) lasts++;
      end
      step();
    end
    chk("t4_pop_count",  32'(pops), 32'd40);
    chk("t4_last_count", 32'(lasts), 32'd10);
    chk("t4_last_pos",   32'(bad), 32'd0);

    // Flush with one word buffered and one returning from the FIFO
    m_ready = 1'b0;
    push_words(32'h501, 4);
    step();
    step();
    flush = 1'b1;
    @(negedge clk_i);
    chk("t5_pre_valid", 32'(valid16), 32'd1);
    chk("t5_pre_data",  data16, 32'h501);
    chk("t5_pre_cnt",   32'(cnt16), 32'd8);
    chk("t5_flush_rd",  32'(rd16), 32'd0);
    step();
    flush = 1'b0;
    chk("t5_post_valid", 32'(valid16), 32'd0);
    chk("t5_post_cnt",   32'(cnt16), 32'd0);
    m_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (valid16 && m_ready) got.push_back(data16);
      step();
    end
    chk("t5_pop_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("t5_next_word", got[0], 32'h503);
      chk("t5_last_word", got[1], 32'h504);
    end

    // Asynchronous reset in the middle of a frame
    pulse_flush();
    m_ready = 1'b0;
    push_words(32'h601, 10);
    m_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (cnt16 == 16'd5) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t6_reach_cnt5", 32'(seen), 32'd1);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("t6_async_valid", 32'(valid16), 32'd0);
    chk("t6_async_last",  32'(last16),  32'd0);
    chk("t6_async_data",  data16,       32'd0);
    chk("t6_async_cnt",   32'(cnt16),   32'd0);
    chk("t6_async_rd",    32'(rd16),    32'd0);
    step();
    step();
    rstn_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (valid16 && m_ready) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("t6_pop_after_reset", 32'(seen), 32'd1);
    step();
    chk("t6_cnt_after_pop", 32'(cnt16), 32'd1);

    repeat (20) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
